// File: rtl/capture_period_meas.sv
// Edge-to-edge period capture with missing-tooth gap detection and timer overflow tracking.
module capture_period_meas #(
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned TCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              edge_in,
    output logic [WIDTH-1:0]  period,
    output logic [WIDTH-1:0]  period_prev,
    output logic              cap_stb,
    output logic              valid,
    output logic              gap,
    output logic [TCNT_W-1:0] tooth_cnt,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        OVF  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]  TIMER_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0]  TIMER_MAX = '1;
    localparam logic [TCNT_W-1:0] TCNT_MAX  = '1;

    state_t              state;
    state_t              state_nxt;
    logic [WIDTH-1:0]    timer;
    logic [WIDTH-1:0]    timer_nxt;
    logic [WIDTH-1:0]    period_nxt;
    logic [WIDTH-1:0]    period_prev_nxt;
    logic                cap_stb_nxt;
    logic                valid_nxt;
    logic                gap_nxt;
    logic [TCNT_W-1:0]   tooth_cnt_nxt;
    logic [TCNT_W-1:0]   tooth_inc;
    logic                ovf_nxt;
    logic                prev_vld;
    logic                prev_vld_nxt;
    logic [WIDTH:0]      gap_thr;
    logic                is_gap;

    // State and datapath registers; async active-low reset clears all history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            timer       <= '0;
            period      <= '0;
            period_prev <= '0;
            cap_stb     <= 1'b0;
            valid       <= 1'b0;
            gap         <= 1'b0;
            tooth_cnt   <= '0;
            ovf         <= 1'b0;
            prev_vld    <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            period      <= period_nxt;
            period_prev <= period_prev_nxt;
            cap_stb     <= cap_stb_nxt;
            valid       <= valid_nxt;
            gap         <= gap_nxt;
            tooth_cnt   <= tooth_cnt_nxt;
            ovf         <= ovf_nxt;
            prev_vld    <= prev_vld_nxt;
        end
    end

    // Next-state, timer, capture and gap logic; strobes default low so they last one cycle.
    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer;
        period_nxt      = period;
        period_prev_nxt = period_prev;
        cap_stb_nxt     = 1'b0;
        gap_nxt         = 1'b0;
        tooth_cnt_nxt   = tooth_cnt;
        ovf_nxt         = ovf;
        prev_vld_nxt    = prev_vld;

        // 1.5x the last period, kept one bit wider so the sum never wraps
        gap_thr   = {1'b0, period} + {2'b00, period[WIDTH-1:1]};
        is_gap    = prev_vld && ({1'b0, timer} >= gap_thr);
        tooth_inc = (tooth_cnt == TCNT_MAX) ? tooth_cnt : tooth_cnt + TCNT_W'(1);

        if (ena) begin
            case (state)
                IDLE: begin
                    timer_nxt = '0;
                    if (edge_in) begin
                        state_nxt = ARM;
                        timer_nxt = TIMER_ONE;
                    end
                end
                ARM: begin
                    if (edge_in) begin
                        state_nxt     = RUN;
                        period_nxt    = timer;
                        timer_nxt     = TIMER_ONE;
                        cap_stb_nxt   = 1'b1;
                        prev_vld_nxt  = 1'b1;
                        tooth_cnt_nxt = tooth_inc;
                    end else if (timer == TIMER_MAX) begin
                        state_nxt    = OVF;
                        ovf_nxt      = 1'b1;
                        prev_vld_nxt = 1'b0;
                    end else begin
                        timer_nxt = timer + WIDTH'(1);
                    end
                end
                RUN: begin
                    if (edge_in) begin
                        period_prev_nxt = period;
                        period_nxt      = timer;
                        timer_nxt       = TIMER_ONE;
                        cap_stb_nxt     = 1'b1;
                        if (is_gap) begin
                            gap_nxt       = 1'b1;
                            tooth_cnt_nxt = '0;
                        end else begin
                            tooth_cnt_nxt = tooth_inc;
                        end
                    end else if (timer == TIMER_MAX) begin
                        state_nxt    = OVF;
                        ovf_nxt      = 1'b1;
                        prev_vld_nxt = 1'b0;
                    end else begin
                        timer_nxt = timer + WIDTH'(1);
                    end
                end
                OVF: begin
                    if (edge_in) begin
                        state_nxt     = ARM;
                        ovf_nxt       = 1'b0;
                        timer_nxt     = TIMER_ONE;
                        tooth_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        valid_nxt = (state_nxt == RUN);
    end

endmodule

// File: tb/tb_capture_period_meas.sv
// Scoreboard bench: stimulus pushes expected captures, per-DUT monitors pop and compare on cap_stb.
module tb_capture_period_meas;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 24-bit instance
    logic        rst0, ena0, edge0;
    logic [23:0] period0, prev0;
    logic        cap0, valid0, gap0, ovf0;
    logic [7:0]  tc0;

    // 8-bit instance for overflow/saturation cases
    logic        rst1, ena1, edge1;
    logic [7:0]  period1, prev1;
    logic        cap1, valid1, gap1, ovf1;
    logic [7:0]  tc1;

    capture_period_meas #(.WIDTH(24), .TCNT_W(8)) dut24 (
        .clk(clk), .rst(rst0), .ena(ena0), .edge_in(edge0),
        .period(period0), .period_prev(prev0), .cap_stb(cap0), .valid(valid0),
        .gap(gap0), .tooth_cnt(tc0), .ovf(ovf0)
    );

    capture_period_meas #(.WIDTH(8), .TCNT_W(8)) dut8 (
        .clk(clk), .rst(rst1), .ena(ena1), .edge_in(edge1),
        .period(period1), .period_prev(prev1), .cap_stb(cap1), .valid(valid1),
        .gap(gap1), .tooth_cnt(tc1), .ovf(ovf1)
    );

    typedef struct packed {
        logic [23:0] per;
        logic [23:0] prev;
        logic        gp;
        logic [7:0]  tc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int sel);
        if (sel == 0) edge0 = 1'b1; else edge1 = 1'b1;
        @(posedge clk);
        #1;
        edge0 = 1'b0;
        edge1 = 1'b0;
    endtask

    // Edge n cycles after the previous one, expecting the given capture.
    task automatic capture(input int sel, input int n, input int per, input int prv,
                           input bit gp, input int tc);
        exp_t e;
        idle(n - 1);
        e.per  = 24'(per);
        e.prev = 24'(prv);
        e.gp   = gp;
        e.tc   = 8'(tc);
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        pulse(sel);
    endtask

    // Monitor for the 24-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (gap0 && !cap0) chk("d24 gap_without_cap", 32'(gap0), 32'd0);
        if (cap0) begin
            if (q0.size() == 0) begin
                chk("d24 unexpected_cap_stb", 32'(cap0), 32'd0);
            end else begin
                e = q0.pop_front();
                chk("d24 period", 32'(period0), 32'(e.per));
                chk("d24 period_prev", 32'(prev0), 32'(e.prev));
                chk("d24 gap", 32'(gap0), 32'(e.gp));
                chk("d24 tooth_cnt", 32'(tc0), 32'(e.tc));
                chk("d24 valid", 32'(valid0), 32'd1);
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (gap1 && !cap1) chk("d8 gap_without_cap", 32'(gap1), 32'd0);
        if (cap1) begin
            if (q1.size() == 0) begin
                chk("d8 unexpected_cap_stb", 32'(cap1), 32'd0);
            end else begin
                e = q1.pop_front();
                chk("d8 period", 32'(period1), 32'(e.per));
                chk("d8 period_prev", 32'(prev1), 32'(e.prev));
                chk("d8 gap", 32'(gap1), 32'(e.gp));
                chk("d8 tooth_cnt", 32'(tc1), 32'(e.tc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b0; ena0 = 1'b1; edge0 = 1'b0;
        rst1 = 1'b0; ena1 = 1'b1; edge1 = 1'b0;
        idle(3);

        // Reset state of the 24-bit instance
        chk("d24 rst period", 32'(period0), 32'd0);
        chk("d24 rst period_prev", 32'(prev0), 32'd0);
        chk("d24 rst cap_stb", 32'(cap0), 32'd0);
        chk("d24 rst valid", 32'(valid0), 32'd0);
        chk("d24 rst gap", 32'(gap0), 32'd0);
        chk("d24 rst tooth_cnt", 32'(tc0), 32'd0);
        chk("d24 rst ovf", 32'(ovf0), 32'd0);
        rst0 = 1'b1;
        idle(2);

        // Periodic edges every 100 cycles
        pulse(0);
        chk("d24 arm valid", 32'(valid0), 32'd0);
        capture(0, 100, 100, 0, 1'b0, 1);
        chk("d24 run valid", 32'(valid0), 32'd1);
        capture(0, 100, 100, 100, 1'b0, 2);
        capture(0, 100, 100, 100, 1'b0, 3);
        chk("d24 tooth_cnt after 4 edges", 32'(tc0), 32'd3);

        // Gap detection and threshold boundary
        capture(0, 200, 200, 100, 1'b1, 0);
        capture(0, 100, 100, 200, 1'b0, 1);
        capture(0, 100, 100, 100, 1'b0, 2);
        capture(0, 149, 149, 100, 1'b0, 3);
        capture(0, 100, 100, 149, 1'b0, 4);
        capture(0, 150, 150, 100, 1'b1, 0);

        // Enable hold: 20 enabled cycles, 50 disabled with strobes, then 80 enabled
        idle(20);
        ena0 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            edge0 = ((i % 10) == 5);
            @(posedge clk);
            #1;
        end
        edge0 = 1'b0;
        chk("d24 hold tooth_cnt", 32'(tc0), 32'd0);
        chk("d24 hold period", 32'(period0), 32'd150);
        ena0 = 1'b1;
        capture(0, 80, 100, 150, 1'b0, 1);

        // Reset mid-run, then two edges before the next capture
        idle(5);
        rst0 = 1'b0;
        #2;
        chk("d24 midrst period", 32'(period0), 32'd0);
        chk("d24 midrst period_prev", 32'(prev0), 32'd0);
        chk("d24 midrst valid", 32'(valid0), 32'd0);
        chk("d24 midrst tooth_cnt", 32'(tc0), 32'd0);
        idle(2);
        rst0 = 1'b1;
        idle(2);
        pulse(0);
        capture(0, 50, 50, 0, 1'b0, 1);
        idle(3);

        // Reset state of the 8-bit instance
        chk("d8 rst ovf", 32'(ovf1), 32'd0);
        chk("d8 rst valid", 32'(valid1), 32'd0);
        rst1 = 1'b1;
        idle(2);

        // Edge coincident with timer saturation
        pulse(1);
        capture(1, 255, 255, 0, 1'b0, 1);
        chk("d8 sat ovf", 32'(ovf1), 32'd0);
        chk("d8 sat valid", 32'(valid1), 32'd1);

        // Overflow with no edge
        idle(254);
        chk("d8 pre-ovf ovf", 32'(ovf1), 32'd0);
        idle(1);
        chk("d8 ovf set", 32'(ovf1), 32'd1);
        chk("d8 ovf valid", 32'(valid1), 32'd0);
        idle(45);
        chk("d8 ovf sticky", 32'(ovf1), 32'd1);
        pulse(1);
        chk("d8 ovf exit ovf", 32'(ovf1), 32'd0);
        chk("d8 ovf exit valid", 32'(valid1), 32'd0);
        chk("d8 ovf exit tooth_cnt", 32'(tc1), 32'd0);
        chk("d8 ovf exit period held", 32'(period1), 32'd255);
        capture(1, 80, 80, 0, 1'b0, 1);
        idle(3);

        chk("d24 pending captures", 32'(q0.size()), 32'd0);
        chk("d8 pending captures", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
